// File: rtl/hazard_pkg.sv
// Shared widths, MD operation codes and default MD latencies for the hazard/stall controller.
package hazard_pkg;

    localparam int TUSE_W = 2;
    localparam int TNEW_W = 2;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;
    localparam int CNT_W_DEF       = 4;

    typedef enum logic [1:0] {
        MD_NONE = 2'd0,
        MD_MULT = 2'd1,
        MD_DIV  = 2'd2
    } md_op_e;

    // Tnew ages by one stage per cycle but never goes below zero.
    function automatic logic [TNEW_W-1:0] sat_dec(input logic [TNEW_W-1:0] v);
        return (v == '0) ? v : v - TNEW_W'(1);
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// D-stage hazard inputs and stall/tracking outputs of hazard_stall_ctrl.
// HAZARD_STATS_EN adds the stall statistics counters.
interface hazard_stall_ctrl_if;
    import hazard_pkg::*;

    logic [4:0]        D_A1;
    logic [4:0]        D_A2;
    logic              D_Use_1;
    logic              D_Use_2;
    logic [TUSE_W-1:0] D_Tuse_1;
    logic [TUSE_W-1:0] D_Tuse_2;
    logic [4:0]        D_A3;
    logic [TNEW_W-1:0] D_Tnew;
    logic [1:0]        D_md_start;
    logic              D_md_use;

    logic              stall;
    logic              D_en;
    logic              E_clr;
    logic [4:0]        E_A3;
    logic [4:0]        M_A3;
    logic [4:0]        W_A3;
    logic              md_busy;
`ifdef HAZARD_STATS_EN
    logic [31:0]       stall_cnt;
    logic [31:0]       md_stall_cnt;
`endif

    modport master (
        output D_A1, D_A2, D_Use_1, D_Use_2, D_Tuse_1, D_Tuse_2,
               D_A3, D_Tnew, D_md_start, D_md_use,
`ifdef HAZARD_STATS_EN
        input  stall_cnt, md_stall_cnt,
`endif
        input  stall, D_en, E_clr, E_A3, M_A3, W_A3, md_busy
    );

    modport slave (
        input  D_A1, D_A2, D_Use_1, D_Use_2, D_Tuse_1, D_Tuse_2,
               D_A3, D_Tnew, D_md_start, D_md_use,
`ifdef HAZARD_STATS_EN
        output stall_cnt, md_stall_cnt,
`endif
        output stall, D_en, E_clr, E_A3, M_A3, W_A3, md_busy
    );

endinterface

// File: rtl/md_busy_counter.sv
// MD unit busy countdown: loads the mult/div latency on issue from E, then counts down to idle.
module md_busy_counter
    import hazard_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] start_i,
    output logic       busy_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // A new issue always reloads, even if a previous operation is still counting.
    always_comb begin
        cnt_d = cnt_q;
        if (start_i == MD_MULT) begin
            cnt_d = CNT_W'(MULT_CYCLES);
        end else if (start_i == MD_DIV) begin
            cnt_d = CNT_W'(DIV_CYCLES);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall/flush controller: E/M/W destination tracking, Tuse/Tnew compare, MD stalls.
// HAZARD_STATS_EN adds saturating stall_cnt / md_stall_cnt statistics.
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    hazard_stall_ctrl_if.slave bus
);

    logic [4:0]        e_a3_q, e_a3_d, m_a3_q, w_a3_q;
    logic [TNEW_W-1:0] e_tnew_q, e_tnew_d, m_tnew_q;
    logic [1:0]        e_md_q, e_md_d;
    logic              rs_hit, rt_hit, md_hit, stall, md_busy;

    // Use gates the address compare so X on an unused index cannot reach stall.
    always_comb begin
        rs_hit = 1'b0;
        rt_hit = 1'b0;
        if (bus.D_Use_1 && (bus.D_A1 != 5'd0)) begin
            rs_hit = ((bus.D_A1 == e_a3_q) && (e_tnew_q > bus.D_Tuse_1)) ||
                     ((bus.D_A1 == m_a3_q) && (m_tnew_q > bus.D_Tuse_1));
        end
        if (bus.D_Use_2 && (bus.D_A2 != 5'd0)) begin
            rt_hit = ((bus.D_A2 == e_a3_q) && (e_tnew_q > bus.D_Tuse_2)) ||
                     ((bus.D_A2 == m_a3_q) && (m_tnew_q > bus.D_Tuse_2));
        end
        md_hit = (bus.D_md_use || (bus.D_md_start != MD_NONE)) &&
                 (md_busy || (e_md_q != MD_NONE));
        stall  = !reset && (rs_hit || rt_hit || md_hit);

        e_a3_d   = stall ? 5'd0 : bus.D_A3;
        e_tnew_d = stall ? '0   : bus.D_Tnew;
        e_md_d   = stall ? 2'd0 : bus.D_md_start;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_a3_q   <= '0;
            e_tnew_q <= '0;
            e_md_q   <= '0;
            m_a3_q   <= '0;
            m_tnew_q <= '0;
            w_a3_q   <= '0;
        end else begin
            e_a3_q   <= e_a3_d;
            e_tnew_q <= e_tnew_d;
            e_md_q   <= e_md_d;
            m_a3_q   <= e_a3_q;
            m_tnew_q <= sat_dec(e_tnew_q);
            w_a3_q   <= m_a3_q;
        end
    end

    md_busy_counter #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_md_busy_counter (
        .clk     (clk),
        .reset   (reset),
        .start_i (e_md_q),
        .busy_o  (md_busy)
    );

    assign bus.stall   = stall;
    assign bus.D_en    = !stall;
    assign bus.E_clr   = stall;
    assign bus.E_A3    = e_a3_q;
    assign bus.M_A3    = m_a3_q;
    assign bus.W_A3    = w_a3_q;
    assign bus.md_busy = md_busy;

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d, md_stall_cnt_q, md_stall_cnt_d;

    always_comb begin
        stall_cnt_d    = stall_cnt_q;
        md_stall_cnt_d = md_stall_cnt_q;
        if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (stall && !rs_hit && !rt_hit && (md_stall_cnt_q != 32'hFFFF_FFFF)) begin
            md_stall_cnt_d = md_stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q    <= '0;
            md_stall_cnt_q <= '0;
        end else begin
            stall_cnt_q    <= stall_cnt_d;
            md_stall_cnt_q <= md_stall_cnt_d;
        end
    end

    assign bus.stall_cnt    = stall_cnt_q;
    assign bus.md_stall_cnt = md_stall_cnt_q;
`endif

endmodule
